// File: rtl/interconn_pkg.sv
// Shared types and default sizing for the interconnect round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interconn_pkg;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_NUM_SLAVES  = 3;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/interconn_rr_picker.sv
// Round-robin picker: one-hot winner, searching upward from ptr_i and wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to consume the winner.
// Ports: req_i request vector, ptr_i starting index (< N), gnt_o one-hot winner or zero.
module interconn_rr_picker #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    int idx;

    // Walk the offsets from farthest to nearest so the requester closest to
    // ptr_i is the last one written and therefore wins.
    always_comb begin
        gnt_o = '0;
        idx   = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr_i) + off) % N;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interconn_rr_arbiter.sv
// Bus arbiter: IDLE/ARB/BUSY FSM, resumed-split priority then round-robin, split parking, timeout.
// Latency: grant two edges after an eligible request is sampled in IDLE; outputs drop one edge after release.
// Backpressure: owner holds the bus until tx_done, request drop, slave split or timeout.
// Ports: MASTER_CLK/MASTER_RST clock and sync reset; M_RQST/M_SLAVE_SEL per-master requests;
//        tx_done and S_SPLIT_EN release events; M_GRANT/bus_grant/slave_select/BUS_BUSY/ARB_BUSY
//        grant state; split_pending parked masters; timeout_err forced-release pulse.
module interconn_rr_arbiter
    import interconn_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int MW = $clog2(NUM_MASTERS + 1),
    localparam int SW = $clog2(NUM_SLAVES)
) (
    input  logic                      MASTER_CLK,
    input  logic                      MASTER_RST,
    input  logic [NUM_MASTERS-1:0]    M_RQST,
    input  logic [NUM_MASTERS*SW-1:0] M_SLAVE_SEL,
    input  logic                      tx_done,
    input  logic [NUM_SLAVES-1:0]     S_SPLIT_EN,
    output logic [NUM_MASTERS-1:0]    M_GRANT,
    output logic [MW-1:0]             bus_grant,
    output logic [SW-1:0]             slave_select,
    output logic                      BUS_BUSY,
    output logic                      ARB_BUSY,
    output logic [NUM_MASTERS-1:0]    split_pending,
    output logic                      timeout_err
);

    localparam int             PW     = $clog2(NUM_MASTERS);
    localparam logic [SW:0]    NS_LIM = NUM_SLAVES[SW:0];
    localparam logic [15:0]    TO_LIM = TIMEOUT_CYC[15:0];

    arb_state_e             state_q;
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          owner_q;
    logic [NUM_MASTERS-1:0] split_pend_q;
    logic [NUM_MASTERS-1:0] resumed_q;
    logic [SW-1:0]          split_slv_q [NUM_MASTERS];
    logic [15:0]            cnt_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [MW-1:0]          bus_grant_q;
    logic [SW-1:0]          slave_sel_q;
    logic                   bus_busy_q;
    logic                   arb_busy_q;
    logic                   timeout_q;

    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] resumed_elig;
    logic [NUM_MASTERS-1:0] pick_req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [PW-1:0]          win_idx;
    logic [SW-1:0]          win_sel;
    logic [PW-1:0]          ptr_d;
    logic                   split_hit;
    logic                   timed_out;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            elig[i] = M_RQST[i] && !split_pend_q[i] &&
                      ({1'b0, M_SLAVE_SEL[i*SW +: SW]} < NS_LIM);
        end
        // A master whose split slave has let go jumps ahead of round-robin.
        resumed_elig = elig & resumed_q;
        pick_req     = (|resumed_elig) ? resumed_elig : elig;

        win_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_gnt[i]) begin
                win_idx = PW'(i);
            end
        end
        win_sel = M_SLAVE_SEL[int'(win_idx)*SW +: SW];

        ptr_d     = (owner_q == PW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
        split_hit = S_SPLIT_EN[slave_sel_q];
        timed_out = (cnt_q == TO_LIM);
    end

    interconn_rr_picker #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_picker (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt)
    );

    always_ff @(posedge MASTER_CLK) begin
        if (MASTER_RST) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            split_pend_q <= '0;
            resumed_q    <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            bus_grant_q  <= '0;
            slave_sel_q  <= '0;
            bus_busy_q   <= 1'b0;
            arb_busy_q   <= 1'b0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                split_slv_q[i] <= '0;
            end
        end else begin
            timeout_q <= 1'b0;

            // Parked masters are released as soon as their slave drops split.
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (split_pend_q[i] && !S_SPLIT_EN[split_slv_q[i]]) begin
                    split_pend_q[i] <= 1'b0;
                    resumed_q[i]    <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        state_q    <= ARB;
                        arb_busy_q <= 1'b1;
                    end
                end
                ARB: begin
                    arb_busy_q <= 1'b0;
                    if (|elig) begin
                        state_q            <= BUSY;
                        grant_q            <= pick_gnt;
                        bus_grant_q        <= MW'(int'(win_idx) + 1);
                        slave_sel_q        <= win_sel;
                        bus_busy_q         <= 1'b1;
                        owner_q            <= win_idx;
                        cnt_q              <= 16'd1;
                        resumed_q[win_idx] <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (tx_done || split_hit || !M_RQST[owner_q] || timed_out) begin
                        state_q     <= IDLE;
                        grant_q     <= '0;
                        bus_grant_q <= '0;
                        slave_sel_q <= '0;
                        bus_busy_q  <= 1'b0;
                        cnt_q       <= '0;
                        ptr_q       <= ptr_d;
                        // tx_done outranks a simultaneous split; timeout only
                        // flags when nothing else ended the grant.
                        if (!tx_done && split_hit) begin
                            split_pend_q[owner_q] <= 1'b1;
                            split_slv_q[owner_q]  <= slave_sel_q;
                        end else if (!tx_done && M_RQST[owner_q]) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign M_GRANT       = grant_q;
    assign bus_grant     = bus_grant_q;
    assign slave_select  = slave_sel_q;
    assign BUS_BUSY      = bus_busy_q;
    assign ARB_BUSY      = arb_busy_q;
    assign split_pending = split_pend_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_interconn_rr_arbiter.sv
// Directed bench: two arbiter instances (2 masters / timeout 8, and 4 masters / timeout 255).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_interconn_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: 2 masters, 3 slaves, timeout 8
    logic [1:0] a_rqst, a_grant, a_bg, a_ss, a_sp;
    logic [3:0] a_sel;
    logic [2:0] a_split;
    logic       a_done, a_bbusy, a_abusy, a_to;

    // Instance B: 4 masters, 3 slaves, timeout 255
    logic [3:0] b_rqst, b_grant, b_sp;
    logic [7:0] b_sel;
    logic [2:0] b_split, b_bg;
    logic [1:0] b_ss;
    logic       b_done, b_bbusy, b_abusy, b_to;

    int n_checks = 0;
    int n_errors = 0;

    interconn_rr_arbiter #(.NUM_MASTERS(2), .NUM_SLAVES(3), .TIMEOUT_CYC(8)) u_dut_a (
        .MASTER_CLK(clk), .MASTER_RST(rst), .M_RQST(a_rqst), .M_SLAVE_SEL(a_sel),
        .tx_done(a_done), .S_SPLIT_EN(a_split), .M_GRANT(a_grant), .bus_grant(a_bg),
        .slave_select(a_ss), .BUS_BUSY(a_bbusy), .ARB_BUSY(a_abusy),
        .split_pending(a_sp), .timeout_err(a_to)
    );

    interconn_rr_arbiter #(.NUM_MASTERS(4), .NUM_SLAVES(3), .TIMEOUT_CYC(255)) u_dut_b (
        .MASTER_CLK(clk), .MASTER_RST(rst), .M_RQST(b_rqst), .M_SLAVE_SEL(b_sel),
        .tx_done(b_done), .S_SPLIT_EN(b_split), .M_GRANT(b_grant), .bus_grant(b_bg),
        .slave_select(b_ss), .BUS_BUSY(b_bbusy), .ARB_BUSY(b_abusy),
        .split_pending(b_sp), .timeout_err(b_to)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for instance B to hold a grant.
    task automatic b_wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (b_bbusy) begin
                ok = 1'b1;
                return;
            end
            tick;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [2:0] exp_bg [5];
        exp_bg[0] = 3'd1; exp_bg[1] = 3'd2; exp_bg[2] = 3'd3; exp_bg[3] = 3'd4; exp_bg[4] = 3'd1;

        rst = 1'b1;
        a_rqst = '0; a_sel = '0; a_done = 1'b0; a_split = '0;
        b_rqst = '0; b_sel = '0; b_done = 1'b0; b_split = '0;
        tick; tick;
        check_val("rst_grant",  32'(a_grant), 0);
        check_val("rst_bg",     32'(a_bg),    0);
        check_val("rst_bbusy",  32'(a_bbusy), 0);
        check_val("rst_abusy",  32'(a_abusy), 0);
        check_val("rst_b_grant", 32'(b_grant), 0);
        rst = 1'b0;

        // Both masters request together: master 0 first, then master 1.
        a_rqst = 2'b11;
        tick;
        check_val("t1_arb",      32'(a_abusy), 1);
        check_val("t1_nogrant",  32'(a_grant), 0);
        tick;
        check_val("t1_g0",       32'(a_grant), 1);
        check_val("t1_bg0",      32'(a_bg),    1);
        check_val("t1_busy",     32'(a_bbusy), 1);
        check_val("t1_arb_off",  32'(a_abusy), 0);
        a_done = 1'b1;
        tick;
        a_done = 1'b0;
        check_val("t1_rel",      32'(a_grant), 0);
        check_val("t1_rel_busy", 32'(a_bbusy), 0);
        tick;
        check_val("t1_arb2",     32'(a_abusy), 1);
        tick;
        check_val("t1_g1",       32'(a_grant), 2);
        check_val("t1_bg1",      32'(a_bg),    2);
        a_rqst = 2'b00;
        tick;
        check_val("t1_drop_rel", 32'(a_grant), 0);
        tick;
        check_val("t1_idle",     32'(a_abusy), 0);

        // Timeout: 8 BUSY cycles, then forced release with a single pulse.
        a_rqst = 2'b01; a_sel = 4'b00_01;
        tick; tick;
        check_val("to_g0",       32'(a_grant), 1);
        check_val("to_ss",       32'(a_ss),    1);
        for (int i = 0; i < 7; i++) begin
            tick;
            check_val("to_hold",    32'(a_grant), 1);
            check_val("to_nopulse", 32'(a_to),    0);
        end
        tick;
        check_val("to_rel",      32'(a_grant), 0);
        check_val("to_pulse",    32'(a_to),    1);
        a_rqst = 2'b00;
        tick;
        check_val("to_once",     32'(a_to),    0);

        // Split: master 0 on slave 2 is parked, master 1 served, master 0 resumes.
        a_rqst = 2'b01; a_sel = 4'b00_10;
        tick; tick;
        check_val("sp_g0",       32'(a_grant), 1);
        check_val("sp_ss",       32'(a_ss),    2);
        a_rqst = 2'b11; a_split = 3'b100;
        tick;
        check_val("sp_rel",      32'(a_grant), 0);
        check_val("sp_pend",     32'(a_sp),    1);
        tick;
        check_val("sp_arb",      32'(a_abusy), 1);
        tick;
        check_val("sp_g1",       32'(a_grant), 2);
        check_val("sp_bg1",      32'(a_bg),    2);
        a_done = 1'b1;
        tick;
        a_done = 1'b0; a_rqst = 2'b01;
        check_val("sp_g1_rel",   32'(a_grant), 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            check_val("sp_parked",   32'(a_grant), 0);
            check_val("sp_pend_hold", 32'(a_sp),   1);
        end
        a_split = 3'b000;
        tick;
        check_val("sp_clear",    32'(a_sp),    0);
        tick;
        check_val("sp_arb2",     32'(a_abusy), 1);
        tick;
        check_val("sp_regrant",  32'(a_grant), 1);
        a_done = 1'b1;
        tick;
        a_done = 1'b0; a_rqst = 2'b00;

        // tx_done and split together: no split recorded.
        a_rqst = 2'b01; a_sel = 4'b00_10;
        tick; tick;
        check_val("ds_g0",       32'(a_grant), 1);
        a_done = 1'b1; a_split = 3'b100;
        tick;
        a_done = 1'b0; a_split = 3'b000;
        check_val("ds_rel",      32'(a_grant), 0);
        check_val("ds_nosplit",  32'(a_sp),    0);
        a_rqst = 2'b00;
        tick;
        check_val("ds_nosplit2", 32'(a_sp),    0);

        // Out-of-range slave select is never granted.
        a_sel = 4'b00_11; a_rqst = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_val("oor_noarb",   32'(a_abusy), 0);
            check_val("oor_nogrant", 32'(a_grant), 0);
        end
        a_rqst = 2'b11;
        tick;
        check_val("oor_arb",     32'(a_abusy), 1);
        tick;
        check_val("oor_g1",      32'(a_grant), 2);
        a_rqst = 2'b00;
        tick;
        check_val("oor_rel",     32'(a_grant), 0);

        // Reset mid-BUSY with ptr at 1.
        a_sel = 4'b00_10; a_rqst = 2'b01;
        tick; tick;
        a_done = 1'b1;
        tick;
        a_done = 1'b0;
        tick; tick;
        check_val("mr_g0",       32'(a_grant), 1);
        check_val("mr_ss",       32'(a_ss),    2);
        rst = 1'b1;
        tick;
        check_val("mr_grant",    32'(a_grant), 0);
        check_val("mr_bg",       32'(a_bg),    0);
        check_val("mr_ss0",      32'(a_ss),    0);
        check_val("mr_bbusy",    32'(a_bbusy), 0);
        rst = 1'b0; a_rqst = 2'b11; a_sel = 4'b00_00;
        tick; tick;
        check_val("mr_ptr0",     32'(a_grant), 1);
        check_val("mr_ptr0_bg",  32'(a_bg),    1);
        a_rqst = 2'b00;
        tick;

        // Four masters, tx_done in every 5th BUSY cycle: order 0,1,2,3,0.
        b_rqst = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            b_wait_grant(ok);
            check_val("rr_wait",    32'(ok),   1);
            check_val("rr_order",   32'(b_bg), 32'(exp_bg[k]));
            check_val("rr_onehot",  32'(b_grant), 32'(1) << (exp_bg[k] - 3'd1));
            repeat (4) tick;
            check_val("rr_hold",    32'(b_bbusy), 1);
            b_done = 1'b1;
            tick;
            b_done = 1'b0;
            check_val("rr_rel",     32'(b_grant), 0);
        end
        b_rqst = 4'b0000;
        tick;

        // Resumed master beats the round-robin pointer.
        b_rqst = 4'b0001; b_sel = 8'b00_00_00_01;
        tick; tick;
        check_val("rs_g0",       32'(b_bg), 1);
        b_split = 3'b010; b_rqst = 4'b0011;
        tick;
        check_val("rs_pend",     32'(b_sp), 1);
        tick; tick;
        check_val("rs_g1",       32'(b_bg), 2);
        b_split = 3'b000;
        tick;
        check_val("rs_clear",    32'(b_sp), 0);
        b_rqst = 4'b0111; b_done = 1'b1;
        tick;
        b_done = 1'b0;
        tick; tick;
        check_val("rs_resume",   32'(b_bg), 1);
        b_done = 1'b1;
        tick;
        b_done = 1'b0; b_rqst = 4'b0000;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/interconn_rr_arbiter.md
INTERCONN_RR_ARBITER -- requirements
Module: interconn_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of requesting masters (2..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 3: number of slaves (2..8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: maximum BUSY cycles per grant (1..65535).
REQ-004 SHALL have derived localparams MW = $clog2(NUM_MASTERS+1) and SW = $clog2(NUM_SLAVES).
REQ-005 SHALL have port MASTER_CLK, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port MASTER_RST, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port M_RQST, input, NUM_MASTERS: bus request, bit i belongs to master i.
REQ-008 SHALL have port M_SLAVE_SEL, input, NUM_MASTERS*SW: target slave index, slice i belongs to master i.
REQ-009 SHALL have port tx_done, input, 1: transfer complete pulse from the current owner.
REQ-010 SHALL have port S_SPLIT_EN, input, NUM_SLAVES: split request, bit j from slave j.
REQ-011 SHALL have port M_GRANT, output, NUM_MASTERS: one-hot grant, or all zero.
REQ-012 SHALL have port bus_grant, output, MW: owner index+1, 0 = no owner (mux select).
REQ-013 SHALL have port slave_select, output, SW: slave index latched at grant.
REQ-014 SHALL have port BUS_BUSY, output, 1: high while any grant is held.
REQ-015 SHALL have port ARB_BUSY, output, 1: high during the ARB decision cycle.
REQ-016 SHALL have port split_pending, output, NUM_MASTERS: bit i high while master i is parked by a split.
REQ-017 SHALL have port timeout_err, output, 1: one-cycle pulse on a forced release.

Function
REQ-018 SHALL register every output.
REQ-019 SHALL implement an FSM with states IDLE, ARB, BUSY.
REQ-020 SHALL treat master i as eligible when M_RQST[i]=1, split_pending[i]=0 and its M_SLAVE_SEL < NUM_SLAVES; out-of-range selects are never granted.
REQ-021 SHALL go IDLE->ARB when any master is eligible, with ARB_BUSY=1 in ARB.
REQ-022 SHALL, in ARB, pick a winner, load M_GRANT, bus_grant, slave_select and BUS_BUSY, and enter BUSY; if no master is still eligible, return to IDLE with no grant.
REQ-023 SHALL give the first grant two cycles after an eligible request is first sampled in IDLE.
REQ-024 SHALL pick the winner in this order: first, a master whose split slave has released (resumed); otherwise, round-robin starting at pointer ptr.
REQ-025 SHALL set ptr to (k+1) mod NUM_MASTERS when master k's grant ends, including wrap-around from NUM_MASTERS-1 to 0.
REQ-026 SHALL, in BUSY, release the grant and go to IDLE on tx_done=1, or when the owner drops M_RQST.
REQ-027 SHALL, in BUSY with S_SPLIT_EN[slave_select]=1 and tx_done=0, release the grant, set split_pending[owner], record the slave index, and go to IDLE.
REQ-028 SHALL give tx_done precedence when tx_done and a split occur in the same cycle; no split is recorded.
REQ-029 SHALL clear split_pending[i] on the cycle its recorded slave deasserts S_SPLIT_EN, and mark master i resumed until its next grant.
REQ-030 SHALL count BUSY cycles and, when the count reaches TIMEOUT_CYC without release, force the grant off, pulse timeout_err, and go to IDLE.
REQ-031 SHALL drop all grant outputs, with BUS_BUSY=0, on the cycle after any release.
REQ-032 SHALL never assert M_GRANT to a master with split_pending set.

Reset
REQ-033 SHALL, on MASTER_RST=1 at a clock edge, set the state to IDLE and clear ptr, split_pending, the resumed flags and the counter.
REQ-034 SHALL hold all outputs at 0 from the first edge of reset, including when reset arrives mid-BUSY; no tx_done is required.
REQ-035 SHALL let reset override every other input.

Structure
REQ-036 SHALL place the state enum (IDLE/ARB/BUSY) and the default parameter constants in the shared package interconn_pkg.
REQ-037 SHALL implement the round-robin pick as one combinational sub-module, interconn_rr_picker (inputs: request vector and pointer; output: one-hot winner).

Verification
REQ-038 SHALL cover: N=2, both M_RQST raised in the same cycle after reset -> master 0 granted first; after tx_done, master 1 granted (bus_grant = 1 then 2).
REQ-039 SHALL cover: N=4, all four masters requesting continuously with tx_done every 5th BUSY cycle -> grant order 0,1,2,3,0 (wrap-around).
REQ-040 SHALL cover: master 0 owns slave 2 and S_SPLIT_EN[2] pulses for 10 cycles -> grant drops, split_pending=01, master 1 is served; after the split releases, master 0 is regranted before round-robin.
REQ-041 SHALL cover: TIMEOUT_CYC=8 with no tx_done -> grant removed after 8 BUSY cycles and timeout_err high for exactly 1 cycle.
REQ-042 SHALL cover: MASTER_RST asserted mid-BUSY -> all outputs 0 on the next edge; ptr=0 afterwards.
REQ-043 SHALL cover: tx_done and S_SPLIT_EN asserted in the same cycle -> split_pending stays 0; M_SLAVE_SEL=3 with NUM_SLAVES=3 -> never granted.
